// File: rtl/program_counter.sv
// Full-width 65c02 program counter: byte loads, increment, relative branch with
// a one-cycle high-byte fixup on page cross, and RES/NMI/IRQ vector loading.
module program_counter #(
  parameter int          WIDTH     = 16,
  parameter logic [15:0] RESET_VAL = 16'hFFFC,
  parameter logic [15:0] VEC_NMI   = 16'hFFFA,
  parameter logic [15:0] VEC_RES   = 16'hFFFC,
  parameter logic [15:0] VEC_IRQ   = 16'hFFFE
) (
  input  logic             fclk,
  input  logic             resb,
  input  logic             ld_lo,
  input  logic             ld_hi,
  input  logic             inc,
  input  logic             br,
  input  logic             vec_ld,
  input  logic [1:0]       vec_sel,
  input  logic             db_sel,
  input  logic [7:0]       db_in,
  output logic [7:0]       db_out,
  output logic [7:0]       address_low_out,
  output logic [WIDTH-9:0] address_high_out,
  output logic             carry_out,
  output logic             br_busy,
  output logic             page_cross
);

  localparam int HW = WIDTH - 8;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FIXUP = 1'b1;

  localparam logic [WIDTH-1:0] RST_PC = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] NMI_PC = VEC_NMI[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RES_PC = VEC_RES[WIDTH-1:0];
  localparam logic [WIDTH-1:0] IRQ_PC = VEC_IRQ[WIDTH-1:0];

  logic [WIDTH-1:0] pc;
  logic [0:0]       state;
  logic             fix_up;
  logic [WIDTH-1:0] vec_pc;
  logic [HW-1:0]    pc_hi;
  logic [8:0]       br_sum;
  logic             br_cross;
  logic [7:0]       pch_ext;

  always_comb begin
    case (vec_sel)
      2'b00:   vec_pc = NMI_PC;
      2'b01:   vec_pc = RES_PC;
      default: vec_pc = IRQ_PC;
    endcase
  end

  assign pc_hi  = pc[WIDTH-1:8];
  assign br_sum = {1'b0, pc[7:0]} + {1'b0, db_in};
  // A forward offset crosses on carry out; a backward one crosses when no carry.
  assign br_cross = db_in[7] ? ~br_sum[8] : br_sum[8];

  always_comb begin
    pch_ext         = '0;
    pch_ext[HW-1:0] = pc_hi;
  end

  assign db_out           = db_sel ? pch_ext : pc[7:0];
  assign address_low_out  = pc[7:0];
  assign address_high_out = pc_hi;

  always_ff @(posedge fclk or negedge resb) begin
    if (!resb) begin
      pc         <= RST_PC;
      state      <= IDLE;
      fix_up     <= 1'b0;
      carry_out  <= 1'b0;
      br_busy    <= 1'b0;
      page_cross <= 1'b0;
    end else begin
      carry_out  <= 1'b0;
      page_cross <= 1'b0;
      if (state == FIXUP) begin
        state   <= IDLE;
        br_busy <= 1'b0;
        if (vec_ld) begin
          pc <= vec_pc;
        end else begin
          pc[WIDTH-1:8] <= fix_up ? pc_hi + HW'(1) : pc_hi - HW'(1);
          page_cross    <= 1'b1;
        end
      end else if (vec_ld) begin
        pc <= vec_pc;
      end else if (ld_lo || ld_hi) begin
        if (ld_lo) pc[7:0] <= db_in;
        if (ld_hi) pc[WIDTH-1:8] <= db_in[HW-1:0];
      end else if (br) begin
        pc[7:0] <= br_sum[7:0];
        if (br_cross) begin
          state   <= FIXUP;
          br_busy <= 1'b1;
          fix_up  <= ~db_in[7];
        end
      end else if (inc) begin
        pc        <= pc + WIDTH'(1);
        carry_out <= (pc[7:0] == 8'hFF);
      end
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: directed vectors push expected state,
// a posedge monitor pops and compares; a second 12-bit instance checks narrow wrap.
module tb_program_counter;

  logic fclk;
  logic resb;

  logic       ld_lo, ld_hi, inc, br, vec_ld, db_sel;
  logic [1:0] vec_sel;
  logic [7:0] db_in;
  logic [7:0] db_out, address_low_out, address_high_out;
  logic       carry_out, br_busy, page_cross;

  logic       n_ld_lo, n_ld_hi, n_inc, n_br, n_vec_ld, n_db_sel;
  logic [1:0] n_vec_sel;
  logic [7:0] n_db_in;
  logic [7:0] n_db_out, n_address_low_out;
  logic [3:0] n_address_high_out;
  logic       n_carry_out, n_br_busy, n_page_cross;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] pc;
    logic        carry;
    logic        busy;
    logic        pcross;
    logic [7:0]  dbo;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   vec_id = 0;

  program_counter dut (
    .fclk(fclk), .resb(resb), .ld_lo(ld_lo), .ld_hi(ld_hi), .inc(inc), .br(br),
    .vec_ld(vec_ld), .vec_sel(vec_sel), .db_sel(db_sel), .db_in(db_in),
    .db_out(db_out), .address_low_out(address_low_out),
    .address_high_out(address_high_out), .carry_out(carry_out),
    .br_busy(br_busy), .page_cross(page_cross)
  );

  program_counter #(.WIDTH(12)) dut12 (
    .fclk(fclk), .resb(resb), .ld_lo(n_ld_lo), .ld_hi(n_ld_hi), .inc(n_inc), .br(n_br),
    .vec_ld(n_vec_ld), .vec_sel(n_vec_sel), .db_sel(n_db_sel), .db_in(n_db_in),
    .db_out(n_db_out), .address_low_out(n_address_low_out),
    .address_high_out(n_address_high_out), .carry_out(n_carry_out),
    .br_busy(n_br_busy), .page_cross(n_page_cross)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  task automatic check_output(input string name, input logic [15:0] actual,
                              input logic [15:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
    end
  endtask

  // Drive one command cycle and queue the state expected after the next rising edge.
  task automatic apply_stimulus(input logic l_lo, input logic l_hi, input logic i_inc,
                                input logic i_br, input logic i_vec, input logic [1:0] vsel,
                                input logic dsel, input logic [7:0] d,
                                input logic [15:0] e_pc, input logic e_carry,
                                input logic e_busy, input logic e_pcross);
    exp_t e;
    @(negedge fclk);
    ld_lo = l_lo; ld_hi = l_hi; inc = i_inc; br = i_br; vec_ld = i_vec;
    vec_sel = vsel; db_sel = dsel; db_in = d;
    e.pc = e_pc; e.carry = e_carry; e.busy = e_busy; e.pcross = e_pcross;
    e.dbo = dsel ? e_pc[15:8] : e_pc[7:0];
    e.id = vec_id;
    vec_id++;
    exp_q.push_back(e);
  endtask

  task automatic idle_cycle(input logic [15:0] e_pc);
    apply_stimulus(0, 0, 0, 0, 0, 2'b00, 0, 8'h00, e_pc, 0, 0, 0);
  endtask

  always @(posedge fclk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_output($sformatf("v%0d pc", e.id), {address_high_out, address_low_out}, e.pc);
      check_output($sformatf("v%0d db_out", e.id), {8'h00, db_out}, {8'h00, e.dbo});
      check_output($sformatf("v%0d carry_out", e.id), {15'h0, carry_out}, {15'h0, e.carry});
      check_output($sformatf("v%0d br_busy", e.id), {15'h0, br_busy}, {15'h0, e.busy});
      check_output($sformatf("v%0d page_cross", e.id), {15'h0, page_cross}, {15'h0, e.pcross});
    end
  end

  initial begin
    resb = 1'b1;
    ld_lo = 0; ld_hi = 0; inc = 0; br = 0; vec_ld = 0; vec_sel = 2'b00; db_sel = 0; db_in = 8'h00;
    n_ld_lo = 0; n_ld_hi = 0; n_inc = 0; n_br = 0; n_vec_ld = 0; n_vec_sel = 2'b00;
    n_db_sel = 0; n_db_in = 8'h00;

    // Asynchronous reset asserted between edges must take effect immediately.
    #3 resb = 1'b0;
    #1;
    check_output("async reset pc", {address_high_out, address_low_out}, 16'hFFFC);
    check_output("async reset pc12", {4'h0, n_address_high_out, n_address_low_out}, 16'h0FFC);
    @(negedge fclk);
    resb = 1'b1;
    idle_cycle(16'hFFFC);
    idle_cycle(16'hFFFC);
    idle_cycle(16'hFFFC);

    // Loads.
    apply_stimulus(1, 0, 0, 0, 0, 2'b00, 0, 8'h34, 16'hFF34, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 0, 2'b00, 0, 8'h12, 16'h1234, 0, 0, 0);
    apply_stimulus(1, 1, 0, 0, 0, 2'b00, 1, 8'hAB, 16'hABAB, 0, 0, 0);
    apply_stimulus(1, 0, 1, 0, 0, 2'b00, 0, 8'h77, 16'hAB77, 0, 0, 0);

    // Increment with and without low-byte carry, full wrap.
    apply_stimulus(1, 0, 0, 0, 0, 2'b00, 0, 8'hFF, 16'hABFF, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 0, 2'b00, 0, 8'h12, 16'h12FF, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 0, 2'b00, 1, 8'h00, 16'h1300, 1, 0, 0);
    idle_cycle(16'h1300);
    apply_stimulus(1, 1, 0, 0, 0, 2'b00, 0, 8'hFF, 16'hFFFF, 0, 0, 0);
    apply_stimulus(0, 0, 1, 0, 0, 2'b00, 0, 8'h00, 16'h0000, 1, 0, 0);
    apply_stimulus(0, 0, 1, 0, 0, 2'b00, 0, 8'h00, 16'h0001, 0, 0, 0);

    // Vector selection and vector priority over loads.
    apply_stimulus(0, 0, 0, 0, 1, 2'b01, 0, 8'h00, 16'hFFFC, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 2'b11, 0, 8'h00, 16'hFFFE, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0, 1, 2'b00, 0, 8'h55, 16'hFFFA, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1, 2'b10, 0, 8'h00, 16'hFFFE, 0, 0, 0);

    // Forward branch with page cross.
    apply_stimulus(1, 0, 0, 0, 0, 2'b00, 0, 8'hF0, 16'hFFF0, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 0, 2'b00, 0, 8'h10, 16'h10F0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 0, 2'b00, 0, 8'h20, 16'h1010, 0, 1, 0);
    idle_cycle(16'h1110);
    exp_q[exp_q.size()-1].pcross = 1'b1;
    idle_cycle(16'h1110);

    // Backward branch with page cross.
    apply_stimulus(1, 0, 0, 0, 0, 2'b00, 0, 8'h05, 16'h1105, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 0, 2'b00, 0, 8'h10, 16'h1005, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 0, 2'b00, 0, 8'hF0, 16'h10F5, 0, 1, 0);
    apply_stimulus(0, 0, 0, 0, 0, 2'b00, 1, 8'h00, 16'h0FF5, 0, 0, 1);

    // Branches without page cross, forward and backward.
    apply_stimulus(1, 0, 0, 0, 0, 2'b00, 0, 8'h10, 16'h0F10, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 0, 2'b00, 0, 8'h10, 16'h1010, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 0, 2'b00, 0, 8'h05, 16'h1015, 0, 0, 0);
    idle_cycle(16'h1015);
    apply_stimulus(0, 0, 0, 1, 0, 2'b00, 0, 8'hFE, 16'h1013, 0, 0, 0);
    idle_cycle(16'h1013);

    // Vector load aborts FIXUP.
    apply_stimulus(1, 0, 0, 0, 0, 2'b00, 0, 8'hF0, 16'h10F0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 0, 2'b00, 0, 8'h20, 16'h1010, 0, 1, 0);
    apply_stimulus(0, 0, 0, 0, 1, 2'b00, 0, 8'h00, 16'hFFFA, 0, 0, 0);
    idle_cycle(16'hFFFA);

    // inc/ld_lo/br ignored during FIXUP; top-of-memory wrap.
    apply_stimulus(1, 0, 0, 0, 0, 2'b00, 0, 8'hF0, 16'hFFF0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 0, 2'b00, 0, 8'h20, 16'hFF10, 0, 1, 0);
    apply_stimulus(1, 0, 1, 1, 0, 2'b00, 0, 8'h55, 16'h0010, 0, 0, 1);
    idle_cycle(16'h0010);

    // Reset during FIXUP.
    apply_stimulus(1, 0, 0, 0, 0, 2'b00, 0, 8'h05, 16'h0005, 0, 0, 0);
    apply_stimulus(0, 0, 0, 1, 0, 2'b00, 0, 8'hF0, 16'h00F5, 0, 1, 0);
    @(negedge fclk);
    br = 0; db_in = 8'h00;
    #2 resb = 1'b0;
    #1;
    check_output("reset in fixup pc", {address_high_out, address_low_out}, 16'hFFFC);
    check_output("reset in fixup busy", {15'h0, br_busy}, 16'h0000);
    @(negedge fclk);
    resb = 1'b1;
    idle_cycle(16'hFFFC);
    idle_cycle(16'hFFFC);

    // Narrow 12-bit instance.
    @(negedge fclk);
    n_ld_lo = 1; n_ld_hi = 1; n_db_in = 8'hFF; n_db_sel = 1;
    @(posedge fclk); #1;
    check_output("w12 ld pc", {4'h0, n_address_high_out, n_address_low_out}, 16'h0FFF);
    check_output("w12 high", {12'h0, n_address_high_out}, 16'h000F);
    check_output("w12 db_out pch", {8'h00, n_db_out}, 16'h000F);
    @(negedge fclk);
    n_ld_lo = 0; n_ld_hi = 0; n_inc = 1; n_db_sel = 0;
    @(posedge fclk); #1;
    check_output("w12 inc wrap", {4'h0, n_address_high_out, n_address_low_out}, 16'h0000);
    check_output("w12 carry", {15'h0, n_carry_out}, 16'h0001);
    @(negedge fclk);
    n_inc = 0;

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge fclk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain: %0d expectations pending, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
